// File: rtl/regfile_write_bank.sv
// Write side of the general register file: address decode, register storage
// with GR0 hardwired to zero, flat contents bus and a last-write report for
// the hazard/forwarding logic.
module regfile_write_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         LE,
    input  logic [$clog2(NUM_REGS)-1:0]  RW,
    input  logic [DATA_W-1:0]            PW,
    output logic [DATA_W*NUM_REGS-1:0]   Q,
    output logic [NUM_REGS-1:0]          DEC,
    output logic                         WR_VALID,
    output logic [$clog2(NUM_REGS)-1:0]  WR_ADDR,
    output logic [DATA_W-1:0]            WR_DATA,
    output logic [15:0]                  WR_COUNT
);

    localparam int unsigned ADDR_W  = $clog2(NUM_REGS);
    localparam int unsigned COUNT_W = 16;

    // GR1..GRn-1 are real storage; GR0 has none and reads as zero.
    logic [DATA_W-1:0] gr [1:NUM_REGS-1];
    logic              eff_wr;

    // One-hot load enables; DEC[0] is still raised so writes to GR0 remain visible.
    always_comb begin
        DEC = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            DEC[i] = LE && (RW == ADDR_W'(i));
        end
    end

    // A write only takes effect when it targets a real register.
    always_comb begin
        eff_wr = LE && (RW != '0);
    end

    // Register storage; each register loads only on its own enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                gr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (DEC[i]) begin
                    gr[i] <= PW;
                end
            end
        end
    end

    // Flatten register contents onto the read bus; slice 0 is constant zero.
    always_comb begin
        Q = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            Q[i*DATA_W +: DATA_W] = gr[i];
        end
    end

    // Last-write report: one-cycle valid, held address/data, wrapping count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WR_VALID <= 1'b0;
            WR_ADDR  <= '0;
            WR_DATA  <= '0;
            WR_COUNT <= '0;
        end else begin
            WR_VALID <= eff_wr;
            if (eff_wr) begin
                WR_ADDR  <= RW;
                WR_DATA  <= PW;
                WR_COUNT <= WR_COUNT + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: directed scenarios plus a long
// random write run, all checked against an array-based reference model.
module tb_regfile_write_bank;

    logic          clk;
    logic          reset;
    logic          LE;
    logic [4:0]    RW;
    logic [31:0]   PW;
    logic [1023:0] Q;
    logic [31:0]   DEC;
    logic          WR_VALID;
    logic [4:0]    WR_ADDR;
    logic [31:0]   WR_DATA;
    logic [15:0]   WR_COUNT;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_gr [32];
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [15:0] m_count;

    regfile_write_bank #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .LE       (LE),
        .RW       (RW),
        .PW       (PW),
        .Q        (Q),
        .DEC      (DEC),
        .WR_VALID (WR_VALID),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .WR_COUNT (WR_COUNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] model_q();
        logic [1023:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[32*i +: 32] = m_gr[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gr[i] = 32'h0;
        m_valid = 1'b0;
        m_addr  = 5'd0;
        m_data  = 32'h0;
        m_count = 16'h0;
    endtask

    // Architectural effect of one clock edge with the given write request.
    task automatic model_edge(input logic le, input logic [4:0] rw, input logic [31:0] pw);
        if (le === 1'b1 && rw != 5'd0) begin
            m_gr[rw] = pw;
            m_valid  = 1'b1;
            m_addr   = rw;
            m_data   = pw;
            m_count  = m_count + 16'd1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},     Q,        model_q());
        check({tag, ".valid"}, WR_VALID, m_valid);
        check({tag, ".addr"},  WR_ADDR,  m_addr);
        check({tag, ".data"},  WR_DATA,  m_data);
        check({tag, ".count"}, WR_COUNT, m_count);
    endtask

    // Called at a falling edge: drive, check decode, clock, check state.
    task automatic step(input string tag, input logic le, input logic [4:0] rw, input logic [31:0] pw);
        logic [31:0] exp_dec;
        LE = le;
        RW = rw;
        PW = pw;
        #1;
        exp_dec = 32'h0;
        if (le === 1'b1) exp_dec[rw] = 1'b1;
        check({tag, ".dec"}, DEC, exp_dec);
        @(posedge clk);
        model_edge(le, rw, pw);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        LE    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_all("after_reset");
    endtask

    initial begin
        reset = 1'b1;
        LE    = 1'b0;
        RW    = 5'd0;
        PW    = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("por");

        // Basic write to GR5 and its one-cycle valid pulse
        @(negedge clk);
        step("wr5", 1'b1, 5'd5, 32'h1234_5678);
        check("wr5.slice", Q[191:160], 32'h1234_5678);
        step("wr5_idle", 1'b0, 5'd5, 32'h0);

        // Writes to GR0 are decoded but dropped
        step("gr0", 1'b1, 5'd0, 32'hFFFF_FFFF);
        check("gr0.slice", Q[31:0], 32'h0);

        // Sweep every address on consecutive edges from a clean reset
        pulse_reset();
        for (int i = 1; i < 32; i++) begin
            step("sweep", 1'b1, 5'(i), 32'(i) * 32'h0101_0101);
        end
        check("sweep.count", WR_COUNT, 16'd31);
        check("sweep.gr31", Q[1023:992], 32'h1F1F_1F1F);
        step("sweep_end", 1'b0, 5'd0, 32'h0);

        // Hold: LE=0 ignores address and data, including unknown values
        step("gr7", 1'b1, 5'd7, 32'hA5A5_A5A5);
        for (int i = 0; i < 10; i++) step("hold", 1'b0, 5'd7, 32'h0);
        step("hold_x", 1'b0, 5'bxxxxx, 32'hxxxx_xxxx);
        check("hold.gr7", Q[255:224], 32'hA5A5_A5A5);

        // Asynchronous reset between edges clears immediately
        step("gr5_beef", 1'b1, 5'd5, 32'hDEAD_BEEF);
        LE = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async.q",     Q,        1024'h0);
        check("async.valid", WR_VALID, 1'b0);
        check("async.count", WR_COUNT, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("async_release");

        // Random mixed traffic, including GR0 and idle cycles
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'(($urandom_range(0, 3)) != 0), 5'($urandom_range(0, 31)), $urandom());
        end

        // Counter wrap: 65535 effective writes from reset, then one more
        pulse_reset();
        for (int i = 0; i < 65535; i++) begin
            step("fill", 1'b1, 5'($urandom_range(1, 31)), $urandom());
        end
        check("wrap.ffff", WR_COUNT, 16'hFFFF);
        step("wrap", 1'b1, 5'($urandom_range(1, 31)), $urandom());
        check("wrap.zero", WR_COUNT, 16'h0000);

        // Reset held across an edge beats a simultaneous write
        LE    = 1'b1;
        RW    = 5'd3;
        PW    = 32'h55;
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check("rstprio.gr3", Q[127:96], 32'h0);
        check_all("rstprio");

        // First write after release lands on the first edge
        reset = 1'b0;
        step("post_reset", 1'b1, 5'd3, 32'h55);
        check("post_reset.gr3", Q[127:96], 32'h55);
        step("post_idle", 1'b0, 5'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
